// File: rtl/pipelined_cla_addsub_pkg.sv
// pipelined_cla_addsub_pkg: shared adder geometry defaults and ALU add/sub encoding.
package pipelined_cla_addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 8;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
endpackage

// File: rtl/cla_group.sv
// cla_group: one GROUP-bit carry-lookahead slice, every carry flattened from g/p/cin.
module cla_group
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             c_top
);
  logic [GROUP-1:0] g, p;
  logic [GROUP:0] c;
  logic pp;
  always_comb begin
    g = x & y;
    p = x | y;
    c = '0;
    pp = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
  end
  assign s = x ^ y ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign c_top = c[GROUP-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit add/sub, one lookahead group per stage,
// operands skewed forward and finished sum bits deskewed to the output.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int STAGES = WIDTH / GROUP;
  localparam int L = STAGES - 1;
  // a single group spanning the whole word is the degenerate one-stage adder
  if (GROUP < 2 || WIDTH < GROUP || WIDTH % GROUP != 0 || (GROUP > 16 && GROUP != WIDTH)) begin : g_bad_params
    $error("pipelined_cla_addsub: illegal WIDTH=%0d GROUP=%0d", WIDTH, GROUP);
  end
  logic advance;
  logic [WIDTH-1:0] b_cap;
  logic ct_all [STAGES];
  logic out_v_d, out_v_q, cout_d, cout_q, ct_d, ct_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  assign advance = !out_v_q || out_ready;
  assign in_ready = advance;
  assign b_cap = (sub == ALU_SUB) ? ~b : b;
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = WIDTH - k * GROUP;
    logic [RW-1:0] a_in, b_in;
    logic [(k+1)*GROUP-1:0] lo_out;
    logic [GROUP-1:0] s;
    logic v_in, c_in, co;
    cla_group #(.GROUP(GROUP)) u_grp (
      .x(a_in[GROUP-1:0]), .y(b_in[GROUP-1:0]), .cin(c_in),
      .s(s), .cout(co), .c_top(ct_all[k])
    );
    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b_cap;
      assign c_in = sub;
      assign v_in = in_valid;
      assign lo_out = s;
    end else begin : g_body
      localparam int PW = WIDTH - (k - 1) * GROUP;
      logic [RW-1:0] a_d, a_q, b_d, b_q;
      logic [k*GROUP-1:0] lo_d, lo_q;
      logic v_d, v_q, c_d, c_q;
      always_comb begin
        v_d = advance ? g_stg[k-1].v_in : v_q;
        c_d = advance ? g_stg[k-1].co : c_q;
        a_d = advance ? g_stg[k-1].a_in[PW-1:GROUP] : a_q;
        b_d = advance ? g_stg[k-1].b_in[PW-1:GROUP] : b_q;
        lo_d = advance ? g_stg[k-1].lo_out : lo_q;
      end
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          lo_q <= '0;
        end else begin
          v_q <= v_d;
          c_q <= c_d;
          a_q <= a_d;
          b_q <= b_d;
          lo_q <= lo_d;
        end
      end
      assign a_in = a_q;
      assign b_in = b_q;
      assign c_in = c_q;
      assign v_in = v_q;
      assign lo_out = {s, lo_q};
    end
  end
  always_comb begin
    out_v_d = advance ? g_stg[L].v_in : out_v_q;
    sum_d = advance ? g_stg[L].lo_out : sum_q;
    cout_d = advance ? g_stg[L].co : cout_q;
    ct_d = advance ? ct_all[L] : ct_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_v_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ct_q <= 1'b0;
    end else begin
      out_v_q <= out_v_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ct_q <= ct_d;
    end
  end
  assign out_valid = out_v_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign overflow = cout_q ^ ct_q;
  assign zero = (sum_q == '0);
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: GROUP 8/4/32 instances against an integer-arithmetic model.
module tb_pipelined_cla_addsub;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic out_ready = 1'b1;
  logic sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0] iv = '0;
  logic [31:0] sum_w [3];
  logic ir_w [3], ov_w [3], co_w [3], of_w [3], z_w [3];
  int lat_exp [3] = '{4, 8, 1};
  int n_vec = 0;
  int n_bad = 0;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clock = ~clock;

  pipelined_cla_addsub #(.WIDTH(32), .GROUP(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir_w[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov_w[0]), .out_ready(out_ready), .sum(sum_w[0]), .cout(co_w[0]), .overflow(of_w[0]), .zero(z_w[0]));
  pipelined_cla_addsub #(.WIDTH(32), .GROUP(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir_w[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov_w[1]), .out_ready(out_ready), .sum(sum_w[1]), .cout(co_w[1]), .overflow(of_w[1]), .zero(z_w[1]));
  pipelined_cla_addsub #(.WIDTH(32), .GROUP(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir_w[2]), .a(a), .b(b), .sub(sub),
    .out_valid(ov_w[2]), .out_ready(out_ready), .sum(sum_w[2]), .cout(co_w[2]), .overflow(of_w[2]), .zero(z_w[2]));

  // {cout, overflow, sum} from wide integer arithmetic
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sr, ur;
    logic c, o;
    sr = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
    ur = s ? longint'(x) - longint'(y) : longint'(x) + longint'(y);
    c = s ? (ur >= 0) : (ur >= 64'sh1_0000_0000);
    o = (sr > SMAX) || (sr < SMIN);
    return {c, o, ur[31:0]};
  endfunction

  task automatic do_op(input int w, input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       output logic [31:0] rs, output logic rc, output logic ro, output logic rz, output int lat);
    @(negedge clock);
    a = ta;
    b = tb;
    sub = ts;
    iv[w] = 1'b1;
    @(negedge clock);
    iv[w] = 1'b0;
    lat = 1;
    while (!ov_w[w] && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rs = sum_w[w];
    rc = co_w[w];
    ro = of_w[w];
    rz = z_w[w];
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      repeat (2) @(negedge clock);
      for (int w = 0; w < 3; w++) begin
        n_vec++;
        if ({ov_w[w], sum_w[w], co_w[w], of_w[w], ir_w[w], z_w[w]} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
          n_bad++;
          $display("FAIL reset_state ph%0d dut%0d: got v=%b s=%h c=%b o=%b r=%b z=%b, want v=0 s=0 c=0 o=0 r=1 z=1",
                   ph, w, ov_w[w], sum_w[w], co_w[w], of_w[w], ir_w[w], z_w[w]);
        end
      end
      reset_n = 1'b1;
    end
  endtask

  task automatic test_corners;
    logic [31:0] ta [4], tb [4], es [4];
    logic ts [4], ec [4], eo [4];
    logic [31:0] rs;
    logic rc, ro, rz;
    int lat;
    ta = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000005};
    tb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1};
    es = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
    ec = '{1'b1, 1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(0, ta[i], tb[i], ts[i], rs, rc, ro, rz, lat);
      n_vec++;
      if ({rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
        n_bad++;
        $display("FAIL corner%0d result: got s=%h c=%b o=%b, want s=%h c=%b o=%b", i, rs, rc, ro, es[i], ec[i], eo[i]);
      end
      n_vec++;
      if (rz !== (es[i] == 32'h0)) begin
        n_bad++;
        $display("FAIL corner%0d zero: got %b, want %b", i, rz, es[i] == 32'h0);
      end
      n_vec++;
      if (lat != 4) begin
        n_bad++;
        $display("FAIL corner%0d latency: got %0d, want 4", i, lat);
      end
    end
  endtask

  task automatic test_stream;
    logic [33:0] q [$];
    logic [33:0] held, exp_v;
    logic stall, acc, seen;
    int sent, got, cyc;
    stall = 1'b0;
    acc = 1'b0;
    seen = 1'b0;
    held = '0;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 64 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (acc || !iv[0]) begin
        if (sent < 64) begin
          a = $urandom;
          b = $urandom;
          sub = 1'($urandom_range(0, 1));
          iv[0] = 1'b1;
        end else iv[0] = 1'b0;
      end
      acc = 1'b0;
      out_ready = ($urandom_range(0, 99) >= 30);
      #1;
      if (iv[0]) begin
        n_vec++;
        if (ir_w[0] !== !((sent - got) == 4 && !out_ready)) begin
          n_bad++;
          $display("FAIL stream_in_ready: got %b, want %b (in flight %0d, out_ready %b)",
                   ir_w[0], !((sent - got) == 4 && !out_ready), sent - got, out_ready);
        end
      end
      if (stall) begin
        n_vec++;
        if (ov_w[0] !== 1'b1 || {co_w[0], of_w[0], sum_w[0]} !== held) begin
          n_bad++;
          $display("FAIL stream_hold: got v=%b %h, want v=1 %h", ov_w[0], {co_w[0], of_w[0], sum_w[0]}, held);
        end
      end
      stall = ov_w[0] && !out_ready;
      held = {co_w[0], of_w[0], sum_w[0]};
      if (ov_w[0] && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got %h, want no result", held);
        end else begin
          exp_v = q.pop_front();
          if (held !== exp_v) begin
            n_bad++;
            $display("FAIL stream_result%0d: got %h, want %h", got, held, exp_v);
          end
        end
        got++;
      end
      if (iv[0] && ir_w[0]) begin
        q.push_back(model(a, b, sub));
        sent++;
        acc = 1'b1;
      end
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clock);
      seen = seen | ov_w[0];
    end
    n_vec++;
    if (got != 64 || sent != 64 || q.size() != 0 || seen) begin
      n_bad++;
      $display("FAIL stream_count: got %0d out of %0d sent, %0d left, late=%b, want 64/64, 0 left, late=0",
               got, sent, q.size(), seen);
    end
  endtask

  task automatic test_reset_flush;
    logic [31:0] rs;
    logic rc, ro, rz, seen;
    int lat;
    logic [33:0] exp_v;
    seen = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      a = 32'h100 + 32'(i);
      b = 32'h1;
      sub = 1'b0;
      iv[0] = 1'b1;
    end
    @(negedge clock);
    iv[0] = 1'b0;
    @(negedge clock);
    n_vec++;
    if (ov_w[0] !== 1'b1 || sum_w[0] !== 32'h101) begin
      n_bad++;
      $display("FAIL flush_pre: got v=%b s=%h, want v=1 s=00000101", ov_w[0], sum_w[0]);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (ov_w[0] !== 1'b0 || sum_w[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL flush_async: got v=%b s=%h, want v=0 s=00000000", ov_w[0], sum_w[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clock);
      seen = seen | ov_w[0];
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL flush_leak: got out_valid=1 after reset, want 0");
    end
    exp_v = model(32'h12345678, 32'h0000F00D, 1'b1);
    do_op(0, 32'h12345678, 32'h0000F00D, 1'b1, rs, rc, ro, rz, lat);
    n_vec++;
    if ({rc, ro, rs} !== exp_v || lat != 4) begin
      n_bad++;
      $display("FAIL flush_after: got %h lat %0d, want %h lat 4", {rc, ro, rs}, lat, exp_v);
    end
  endtask

  task automatic test_group_variants;
    logic [31:0] rs;
    logic rc, ro, rz;
    int lat;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 2; c++) begin
        do_op(w, 32'hFFFFFFFF, (c == 0) ? 32'h1 : 32'hFFFFFFFF, c == 1, rs, rc, ro, rz, lat);
        n_vec++;
        if ({rs, rc, ro, rz} !== {32'h0, 1'b1, 1'b0, 1'b1} || lat != lat_exp[w]) begin
          n_bad++;
          $display("FAIL group dut%0d case%0d: got s=%h c=%b o=%b z=%b lat %0d, want s=0 c=1 o=0 z=1 lat %0d",
                   w, c, rs, rc, ro, rz, lat, lat_exp[w]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_corners;
    test_stream;
    test_reset_flush;
    test_group_variants;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the processor datapath. It splits a WIDTH-bit operation into WIDTH/GROUP lookahead groups and evaluates one group per pipeline stage, registering the inter-group carry between stages. This keeps the critical path to a single GROUP-bit lookahead, so the ALU closes timing at the full 32-bit width. It adds a subtract mode, carry, overflow and zero flags, and a valid/ready handshake with backpressure.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of GROUP, and WIDTH ≥ GROUP.
- GROUP, 8: bits per lookahead group/stage; legal range 2..16.
- (derived) STAGES = WIDTH/GROUP: pipeline depth and latency.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are presented this cycle.
- in_ready  out  1  the pipeline accepts when in_valid && in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B; 1: A−B (A + ~B + 1).
- out_valid  out  1  the result below is valid.
- out_ready  in  1  the consumer accepts when out_valid && out_ready.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. On subtract, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  high when sum == 0, driven combinationally from the sum register.

## Operation
- Stage k (0..STAGES−1) computes group k, bits [k·GROUP +: GROUP], using a full GROUP-bit lookahead: generate = a&b, propagate = a|b, and the sum is a^b^carry.
- Stage 0 carry-in is `sub`. Operand B is inverted at capture when `sub` = 1.
- The carry-in for stage k>0 is the registered carry-out of stage k−1.
- Unprocessed upper operand groups travel forward in skew registers.
- Completed lower sum groups travel forward in deskew registers. The final stage presents all WIDTH bits aligned.
- The final stage also registers the carry into the MSB. This register is the source of `overflow`.
- Each stage holds a valid bit. A single global `advance` signal moves all stages: advance = !out_valid || out_ready.
- in_ready = advance. The pipeline never drops or duplicates a transaction; results leave in acceptance order.
- On advance with in_valid = 0, a bubble (valid = 0) enters stage 0.
- When advance = 0, every stage register holds its value.

## Timing
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. STAGES cycles.
- Throughput: one operation per cycle while out_ready stays high.
- The output stays stable while out_valid && !out_ready. sum and the flags change only on advance.
- in_ready depends combinationally on out_ready. There is no skid buffer; a full pipeline under stall deasserts in_ready in the same cycle.
- Reset values while reset_n = 0 and after release:
  - all valid bits 0, so out_valid = 0;
  - sum 0, cout 0, overflow 0;
  - in_ready 1;
  - zero 1.
- Reset asserted mid-operation discards every in-flight operation immediately; none emerge after release.
- STAGES = 1 degenerates to a registered single-group adder with latency 1.

## Structure
- A shared package holds the default WIDTH/GROUP constants and the `sub` encoding (ALU_ADD = 0, ALU_SUB = 1). The ALU decode uses the same constants.
- One combinational sub-module, `cla_group`, is instantiated STAGES times via generate.
  - Inputs: GROUP-bit x, y, cin.
  - Outputs: GROUP-bit s, cout, and the carry into the top bit (used for overflow).
- Parameter legality is checked with elaboration-time assertions.

## Test plan
WIDTH = 32, GROUP = 8, latency 4 unless stated.
- Add 0xFFFFFFFF + 0x00000001 -> after 4 cycles: sum 0x00000000, cout 1, overflow 0, zero 1.
- Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout 0, overflow 1, zero 0.
- Subtract 0x80000000 − 0x00000001 -> sum 0x7FFFFFFF, cout 1, overflow 1. Subtract 5 − 7 -> sum 0xFFFFFFFE, cout 0, overflow 0.
- Stream 64 random add/sub operations back-to-back, with out_ready randomly low 30% of cycles -> results match the reference model in order with no loss or duplication. The output holds stable while stalled. in_ready is 0 only when all 4 stages are valid and out_ready = 0.
- Pulse reset_n low for one cycle with 3 operations in flight -> out_valid drops to 0 asynchronously, none of the 3 emerge, and a new operation after release arrives 4 cycles later.
- Re-run the carry-chain cases 0xFFFFFFFF + 1 and 0xFFFFFFFF − 0xFFFFFFFF with GROUP = 4 (latency 8) and GROUP = 32 (latency 1) -> identical results at the derived latency.
